// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared single-cycle ALU and stalls the pipeline while busy.
// Optional MUL_SIGNED_EN adds the mul_signed port and the two's-complement negate states.
module alu_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MUL_SIGNED_EN
    input  logic             mul_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_rd1,
    output logic [WIDTH-1:0] alu_rd2,
    output logic [WIDTH-1:0] alu_imm32,
    output logic [1:0]       alu_op,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    output logic             alu_src,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] DONE  = 3'd2;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] NEG_A = 3'd3;
    localparam logic [2:0] NEG_B = 3'd4;
    localparam logic [2:0] NEG_R = 3'd5;
`endif

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    logic [2:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] product_r;
`ifdef MUL_SIGNED_EN
    logic             neg;
    logic             sgn;
`endif

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign product    = product_r;
    assign alu_imm32  = '0;
    assign alu_op     = 2'b10;
    assign alu_funct3 = 3'b000;
    assign alu_src    = 1'b0;

    // ALU operands are forced to zero whenever the pipeline owns the ALU
    always_comb begin
        alu_sel    = 1'b0;
        alu_rd1    = '0;
        alu_rd2    = '0;
        alu_funct7 = F7_ADD;
        case (state)
            RUN: begin
                alu_sel = 1'b1;
                alu_rd1 = acc;
                alu_rd2 = mcand;
            end
`ifdef MUL_SIGNED_EN
            NEG_A: begin
                alu_sel    = 1'b1;
                alu_rd2    = mcand;
                alu_funct7 = F7_SUB;
            end
            NEG_B: begin
                alu_sel    = 1'b1;
                alu_rd2    = mplier;
                alu_funct7 = F7_SUB;
            end
            NEG_R: begin
                alu_sel    = 1'b1;
                alu_rd2    = acc;
                alu_funct7 = F7_SUB;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            product_r <= '0;
`ifdef MUL_SIGNED_EN
            neg       <= 1'b0;
            sgn       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
`ifdef MUL_SIGNED_EN
                        sgn <= mul_signed;
                        neg <= mul_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        if (mul_signed && op_a[WIDTH-1])
                            state <= NEG_A;
                        else if (mul_signed && op_b[WIDTH-1])
                            state <= NEG_B;
                        else
                            state <= RUN;
`else
                        state <= RUN;
`endif
                    end
                end
`ifdef MUL_SIGNED_EN
                NEG_A: begin
                    mcand <= alu_result;
                    state <= (sgn && mplier[WIDTH-1]) ? NEG_B : RUN;
                end
                NEG_B: begin
                    mplier <= alu_result;
                    state  <= RUN;
                end
                NEG_R: begin
                    acc       <= alu_result;
                    product_r <= alu_result;
                    state     <= DONE;
                end
`endif
                RUN: begin
                    if (mplier[0])
                        acc <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    // The product register is loaded on the way into DONE so it is valid with done
                    if (mplier[WIDTH-1:1] == '0) begin
`ifdef MUL_SIGNED_EN
                        if (neg) begin
                            state <= NEG_R;
                        end else begin
                            state     <= DONE;
                            product_r <= mplier[0] ? alu_result : acc;
                        end
`else
                        state     <= DONE;
                        product_r <= mplier[0] ? alu_result : acc;
`endif
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
